reg_file_32x64: RTL and testbench

REG_FILE_32X64 -- requirements
Module: reg_file_32x64

---
 rtl/reg_file_32x64.sv | 137 +++++++++++++
 tb/tb_reg_file_32x64.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_32x64.sv
// -----------------------------------------------------------------------------
// reg_file_32x64
//
// Purpose:
//   A 32-entry register file with two read ports and one write port.
//   - Reads are combinational, so data appears in the same cycle as the address.
//   - Writes happen on the rising edge of clk.
//   - Register ZERO_REG always reads as zero.
//   - An active-low asynchronous reset clears every register.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN
//     When defined, a read of the register that is being written in the same
//     cycle returns WriteData combinationally (write-to-read forwarding).
//     Forwarding never applies to ZERO_REG or while reset_n is low.
//     When undefined, such a read returns the old value until the edge.
//
// Parameters:
//   WIDTH     data width of every register and data port (default 64)
//   ZERO_REG  index of the hardwired-zero register (default 31)
//
// Ports:
//   clk            in   1      single clock, rising-edge active
//   reset_n        in   1      asynchronous active-low reset
//   RegWrite       in   1      write enable
//   WriteRegister  in   5      write address
//   WriteData      in   WIDTH  write data
//   ReadRegister1  in   5      read port 1 address
//   ReadRegister2  in   5      read port 2 address
//   ReadData1      out  WIDTH  read port 1 data
//   ReadData2      out  WIDTH  read port 2 data
// -----------------------------------------------------------------------------
module reg_file_32x64 #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RegWrite,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam int         NREGS     = 32;
  localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

  // Storage
  logic [WIDTH-1:0] regs [NREGS];

  // One-hot write-enable decoder.
  //
  // The enable is ANDed into every bit. As a result, an X or Z on
  // WriteRegister cannot raise any enable while RegWrite is low.
  logic [NREGS-1:0] we_dec;

  always_comb begin
    we_dec = '0;
    for (int i = 0; i < NREGS; i++) begin
      we_dec[i] = RegWrite && (WriteRegister == 5'(i));
    end
  end

  // Register array with per-register enables.
  //
  // The decoder still accepts a write to the zero register. That register is
  // loaded only with zero, so synthesis reduces it to a constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_dec[i]) begin
          regs[i] <= (i == ZERO_REG) ? '0 : WriteData;
        end
      end
    end
  end

  // Read mux for one port: a 32:1 WIDTH-bit select.
  //
  // The zero register is forced to zero here. Its storage is not consulted.
  function automatic logic [WIDTH-1:0] read_mux(input logic [4:0] addr);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if ((addr == 5'(i)) && (i != ZERO_REG)) begin
        d = regs[i];
      end
    end
    return d;
  endfunction

  logic [WIDTH-1:0] mux1;
  logic [WIDTH-1:0] mux2;

  always_comb begin
    mux1 = read_mux(ReadRegister1);
    mux2 = read_mux(ReadRegister2);
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding of the value being written.
  //
  // Gating with reset_n keeps both outputs at zero during reset. Gating with
  // the zero-register check keeps that register reading zero.
  logic fwd1;
  logic fwd2;

  always_comb begin
    fwd1 = reset_n && RegWrite && (WriteRegister == ReadRegister1) &&
           (WriteRegister != ZERO_ADDR);
    fwd2 = reset_n && RegWrite && (WriteRegister == ReadRegister2) &&
           (WriteRegister != ZERO_ADDR);
  end

  always_comb begin
    ReadData1 = fwd1 ? WriteData : mux1;
    ReadData2 = fwd2 ? WriteData : mux2;
  end
`else
  // No forwarding.
  //
  // A read of the register being written returns the stored (old) value
  // until the edge.
  always_comb begin
    ReadData1 = mux1;
    ReadData2 = mux2;
  end
`endif

endmodule

// File: tb/tb_reg_file_32x64.sv
// -----------------------------------------------------------------------------
// tb_reg_file_32x64
//
// Self-checking bench for reg_file_32x64 (WIDTH=64, ZERO_REG=31).
//
// Checking structure:
//   - An array model of the 32 registers, updated from the architectural rules.
//   - One compare process that checks both read ports on every falling edge.
//   - Directed literal checks at key points of the stimulus.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge, or 1 time unit after the inputs change.
// -----------------------------------------------------------------------------
module tb_reg_file_32x64;

  localparam int W = 64;
  localparam logic [63:0] STEP = 64'h0101010101010101;

  // Clock and reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // DUT signals
  logic         RegWrite;
  logic [4:0]   WriteRegister;
  logic [W-1:0] WriteData;
  logic [4:0]   ReadRegister1;
  logic [4:0]   ReadRegister2;
  logic [W-1:0] ReadData1;
  logic [W-1:0] ReadData2;

  reg_file_32x64 #(.WIDTH(W), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // Counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what every register architecturally holds
  logic [W-1:0] mdl [32];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mdl[i] <= '0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      mdl[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [W-1:0] model_read(input logic [4:0] a);
    if (!reset_n || a == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteRegister == a) return WriteData;
`endif
    return mdl[a];
  endfunction

  // Per-cycle compare process
  always @(negedge clk) begin
    check("port1_model", ReadData1, model_read(ReadRegister1));
    check("port2_model", ReadData2, model_read(ReadRegister2));
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa,
                       input logic [W-1:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    RegWrite      = we;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = ra1;
    ReadRegister2 = ra2;
  endtask

  task automatic write_reg(input logic [4:0] wa, input logic [W-1:0] wd);
    drive(1'b1, wa, wd, wa, wa);
    next_cycle();
    RegWrite = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;

    // Power-up reset
    reset_n = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd0, 5'd1);
    #1;
    check("reset_state_p1", ReadData1, '0);
    check("reset_state_p2", ReadData2, '0);
    next_cycle();
    next_cycle();
    #2 reset_n = 1'b1;           // released mid-cycle
    next_cycle();

    // Write/read sweep X0..X30
    for (int i = 0; i < 31; i++) begin
      v = 64'(i) * STEP;
      drive(1'b1, 5'(i), v, 5'(i), 5'(i));
      next_cycle();
      check("sweep_p1", ReadData1, v);
      check("sweep_p2", ReadData2, v);
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(30 - i);
      #1;
      check("sweep_hold_p1", ReadData1, 64'(i) * STEP);
      check("sweep_hold_p2", ReadData2, 64'(30 - i) * STEP);
    end
    next_cycle();

    // Zero register
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    #1;
    check("zero_before", ReadData1, '0);
    next_cycle();
    check("zero_after", ReadData1, '0);
    RegWrite = 1'b0;

    // Write disable
    drive(1'b0, 5'd3, 64'h1234, 5'd3, 5'd4);
    next_cycle();
    check("wdis_x3", ReadData1, 64'h0303030303030303);
    check("wdis_x4", ReadData2, 64'h0404040404040404);

    // Same-cycle read of the write target
    write_reg(5'd7, 64'hAA);
    drive(1'b1, 5'd7, 64'hBB, 5'd7, 5'd8);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("samecyc_before", ReadData1, 64'hBB);
`else
    check("samecyc_before", ReadData1, 64'hAA);
`endif
    next_cycle();
    check("samecyc_after", ReadData1, 64'hBB);
    RegWrite = 1'b0;

    // Dual-port read
    write_reg(5'd2, 64'h22);
    write_reg(5'd30, 64'h3E);
    drive(1'b0, 5'd0, '0, 5'd2, 5'd30);
    #1;
    check("dual_p1", ReadData1, 64'h22);
    check("dual_p2", ReadData2, 64'h3E);
    next_cycle();

    // Asynchronous reset, mid-cycle
    write_reg(5'd5, 64'hDEAD);
    drive(1'b0, 5'd0, '0, 5'd5, 5'd2);
    #1;
    check("pre_reset_x5", ReadData1, 64'hDEAD);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_x5", ReadData1, '0);
    check("async_reset_x2", ReadData2, '0);

    // A write under reset is ignored: reset wins
    drive(1'b1, 5'd6, 64'h55, 5'd6, 5'd6);
    next_cycle();
    check("reset_write_ignored", ReadData1, '0);
    RegWrite = 1'b0;
    #2 reset_n = 1'b1;
    #1;
    check("after_release_x6", ReadData2, '0);
    next_cycle();

    // First write after release lands on the first enabled edge
    drive(1'b1, 5'd9, 64'h99, 5'd9, 5'd6);
    next_cycle();
    check("first_write_x9", ReadData1, 64'h99);
    check("x6_still_zero", ReadData2, '0);
    RegWrite = 1'b0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
